// File: rtl/zeroriscy_mem_arbiter.sv
// zeroriscy_mem_arbiter: two-master to one-slave req/gnt/rvalid arbiter with in-order response routing.
// Define ARB_ROUND_ROBIN_EN for alternating priority on contention; otherwise m0 always wins.
module zeroriscy_mem_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [3:0]    m0_be,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [31:0]   m0_rdata,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [3:0]    m1_be,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [31:0]   m1_rdata,
    output logic          m1_err,
    output logic          s_req,
    output logic          s_we,
    output logic [3:0]    s_be,
    output logic [AW-1:0] s_addr,
    output logic [31:0]   s_wdata,
    input  logic          s_gnt,
    input  logic          s_rvalid,
    input  logic [31:0]   s_rdata,
    input  logic          s_err,
    output logic          protocol_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [DEPTH-1:0] ids_q, ids_d;
    logic             protocol_err_q, protocol_err_d;
    logic             sel, push, pop, head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    always_comb sel = (m0_req & m1_req) ? ~last_q : m1_req;
    always_comb last_d = push ? sel : last_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`else
    always_comb sel = ~m0_req;
`endif

    // Availability uses the registered count only, keeping s_rvalid off the grant path.
    always_comb begin
        s_req     = rst_n & (cnt_q < CW'(DEPTH)) & (m0_req | m1_req);
        s_we      = sel ? m1_we    : m0_we;
        s_be      = sel ? m1_be    : m0_be;
        s_addr    = sel ? m1_addr  : m0_addr;
        s_wdata   = sel ? m1_wdata : m0_wdata;
        push      = s_req & s_gnt;
        m0_gnt    = push & ~sel;
        m1_gnt    = push & sel;
        pop       = s_rvalid & (cnt_q != '0);
        head      = ids_q[rd_q];
        m0_rvalid = pop & ~head;
        m1_rvalid = pop & head;
        m0_err    = m0_rvalid & s_err;
        m1_err    = m1_rvalid & s_err;
        m0_rdata  = s_rdata;
        m1_rdata  = s_rdata;
    end

    always_comb begin
        cnt_d = (push & ~pop) ? cnt_q + CW'(1) : (pop & ~push) ? cnt_q - CW'(1) : cnt_q;
        wr_d  = push ? ptr_inc(wr_q) : wr_q;
        rd_d  = pop ? ptr_inc(rd_q) : rd_q;
        ids_d = ids_q;
        if (push) ids_d[wr_q] = sel;
        protocol_err_d = protocol_err_q | (s_rvalid & ~pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            wr_q           <= '0;
            rd_q           <= '0;
            ids_q          <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            wr_q           <= wr_d;
            rd_q           <= rd_d;
            ids_q          <= ids_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    assign protocol_err = protocol_err_q;
endmodule
